cond_issue_ctrl: RTL and testbench
==================================

# cond_issue_ctrl

- Issue-stage controller for conditional execution.
- Owns the 4-bit NZCV status register and evaluates each instruction's 4-bit condition field against it.
- Tracks in-flight flag-setting instructions and stalls conditional instructions until their flags are final.
- Sequences the pipeline flush after a taken branch; sits between decode (ID) and execute (EX).

## Interface
Parameters:
- PEND_W, 2, width of the in-flight flag-writer counter (max pending = 2^PEND_W-1)
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds an instruction
- id_ready  out  1  controller accepts the instruction this cycle (combinational)
- id_cond  in  4  condition field
- id_s  in  1  instruction writes flags
- id_branch  in  1  instruction is a branch
- ex_flag_we  in  1  EX writes flags this cycle
- ex_flags  in  4  new flags {N,Z,C,V}
- issue_fire  out  1  id_valid & id_ready
- issue_exec  out  1  issue_fire & condition passed; 0 with issue_fire=1 means issue as bubble
- flush  out  1  squash IF/ID
- status_reg  out  4  registered {N,Z,C,V}
- pending  out  PEND_W  in-flight flag-writer count

## Operation
- Condition codes:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- Flags used for evaluation: status_reg (see Configuration for bypass).
- FSM, two states:
  - RUN: id_ready = ~stall.
  - FLUSH: id_ready=0, flush=1, down-counter from FLUSH_CYCLES-1; returns to RUN after FLUSH_CYCLES cycles.
- stall (RUN only) when either:
  - id_cond!=1110 and pending!=0, or
  - id_s and pending==max and ex_flag_we==0.
- pending update:
  - +1 on issue_exec & id_s; -1 on ex_flag_we & pending!=0.
  - Both in the same cycle: unchanged.
  - ex_flag_we with pending==0: status_reg is still written, pending stays 0 (no underflow).
- status_reg <= ex_flags whenever ex_flag_we, in either state.
- Taken branch (issue_exec & id_branch) moves RUN→FLUSH. A failed branch issues as a bubble with no flush.
- Reset, any state: status_reg=0000, pending=0, state=RUN, flush=0. Outputs settle immediately; a flush in progress is aborted.

## Timing
- id_ready, issue_fire and issue_exec are combinational from registered state plus inputs; no combinational path from ex_flags exists without the bypass.
- Flag-dependent stall, no bypass: ex_flag_we at cycle t → pending=0 and status_reg updated at t+1 → conditional instruction issues at t+1.
- Taken branch issued at cycle t: flush=1 for cycles t+1 … t+FLUSH_CYCLES, id_ready=1 again at t+FLUSH_CYCLES+1.
- AL instructions issue with pending!=0 (subject only to the saturation rule).

## Configuration
- FLAG_BYPASS_EN defined:
  - When ex_flag_we=1 and pending==1, condition evaluation uses ex_flags instead of status_reg.
  - The pending!=0 stall is waived that cycle, so the dependent instruction issues at cycle t.
  - Adds an ex_flags→issue_exec combinational path.
- Not defined: no bypass; one extra stall cycle as in Timing.

## Test plan
- Reset: drive rst mid-FLUSH → status_reg=0000, pending=0, flush=0, id_ready=1 with id_cond=1110, all in the same cycle.
- EQ after flag setter:
  - Stimulus: issue id_s=1 with AL; next cycle id_cond=0000 stalls; ex_flag_we=1 with ex_flags=0100 at cycle t.
  - Required: issue_exec=1 at t+1 without bypass, at t with FLAG_BYPASS_EN.
- Condition sweep: status_reg=1001 (N,V) → GE=1, LT=0, GT=1, LE=0, NV=0, AL=1; status_reg=0010 → HI=1, LS=0.
- Taken branch: id_branch=1, id_cond=1110 at cycle 5 → flush=1 cycles 6–7 (FLUSH_CYCLES=2), id_ready=1 at cycle 8; failed branch (NE with Z=1) → issue_fire=1, issue_exec=0, no flush.
- Saturation:
  - Issue three id_s AL instructions with no ex_flag_we → pending=3.
  - A fourth id_s stalls; it issues in the same cycle that ex_flag_we=1, leaving pending=3.
- Spurious write: ex_flag_we=1 with pending=0, ex_flags=1111 → status_reg=1111, pending stays 0.

Source files
------------

// File: rtl/cond_issue_ctrl.sv
// ---------------------------------------------------------------------------
// cond_issue_ctrl
//
// Issue-stage controller for conditional execution, sitting between decode
// (ID) and execute (EX). It owns the NZCV status register, evaluates each
// instruction's condition field against it, holds back conditional
// instructions while flag writers are still in flight, and sequences the
// IF/ID flush after a taken branch.
//
// Optional feature macro: FLAG_BYPASS_EN
//   When defined, an instruction waiting on the last in-flight flag writer
//   evaluates its condition against ex_flags in the cycle that writer
//   retires, saving one stall cycle (adds an ex_flags -> issue_exec path).
//
// Parameters:
//   PEND_W        width of the in-flight flag-writer counter
//   FLUSH_CYCLES  cycles flush is held after a taken branch (>= 1)
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   id_valid      ID holds an instruction
//   id_ready      instruction accepted this cycle (combinational)
//   id_cond       4-bit condition field
//   id_s          instruction writes flags
//   id_branch     instruction is a branch
//   ex_flag_we    EX writes flags this cycle
//   ex_flags      new flags {N,Z,C,V}
//   issue_fire    id_valid & id_ready
//   issue_exec    issue_fire & condition passed (0 with fire = bubble)
//   flush         squash IF/ID
//   status_reg    registered {N,Z,C,V}
//   pending       in-flight flag-writer count
// ---------------------------------------------------------------------------
module cond_issue_ctrl #(
    parameter int PEND_W       = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_cond,
    input  logic              id_s,
    input  logic              id_branch,
    input  logic              ex_flag_we,
    input  logic [3:0]        ex_flags,
    output logic              issue_fire,
    output logic              issue_exec,
    output logic              flush,
    output logic [3:0]        status_reg,
    output logic [PEND_W-1:0] pending
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam int                CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [3:0]        COND_AL  = 4'b1110;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;

    logic [3:0] eval_flags;
    logic       bypass;
    logic       cond_ok;
    logic       stall;
    logic       inc_pend;
    logic       dec_pend;

    // Condition-code evaluation against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through it leaves a value held and no latch is inferred.
    always_comb begin
        eval_flags = status_reg;
        bypass     = 1'b0;
`ifdef FLAG_BYPASS_EN
        // The last outstanding writer is retiring now: its flags are final.
        if (ex_flag_we && (pending == PEND_ONE)) begin
            bypass     = 1'b1;
            eval_flags = ex_flags;
        end
`endif
        cond_ok = cond_pass(id_cond, eval_flags);

        // Conditional instructions wait for final flags; a new flag writer
        // waits while the counter is full unless a writer retires this cycle.
        stall = ((id_cond != COND_AL) && (pending != '0) && !bypass) ||
                (id_s && (pending == PEND_MAX) && !ex_flag_we);

        id_ready   = (state == ST_RUN) && !stall;
        issue_fire = id_valid && id_ready;
        issue_exec = issue_fire && cond_ok;

        inc_pend = issue_exec && id_s;
        dec_pend = ex_flag_we && (pending != '0);
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            flush_cnt  <= '0;
            flush      <= 1'b0;
            status_reg <= 4'b0000;
            pending    <= '0;
        end else begin
            if (ex_flag_we) begin
                status_reg <= ex_flags;
            end

            // Simultaneous increment and decrement cancel out.
            if (inc_pend && !dec_pend) begin
                pending <= pending + PEND_ONE;
            end else if (dec_pend && !inc_pend) begin
                pending <= pending - PEND_ONE;
            end

            case (state)
                ST_RUN: begin
                    if (issue_exec && id_branch) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= CNT_INIT;
                        flush     <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cond_issue_ctrl
//
// Self-checking bench for cond_issue_ctrl. Directed scenarios compare against
// constants; a randomized phase compares every output each cycle against a
// behavioural model that tracks flags, an integer count of outstanding flag
// writers and the number of flush cycles still owed.
// ---------------------------------------------------------------------------
module tb_cond_issue_ctrl;

    localparam int PEND_W       = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int MAX_PEND     = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic [3:0]        id_cond;
    logic              id_s;
    logic              id_branch;
    logic              ex_flag_we;
    logic [3:0]        ex_flags;
    logic              issue_fire;
    logic              issue_exec;
    logic              flush;
    logic [3:0]        status_reg;
    logic [PEND_W-1:0] pending;

    int n_tests;
    int n_fail;

    // Reference model state
    int         m_pending;
    logic [3:0] m_status;
    int         m_flush_left;
    logic       e_ready, e_fire, e_exec;

    cond_issue_ctrl #(
        .PEND_W       (PEND_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_cond    (id_cond),
        .id_s       (id_s),
        .id_branch  (id_branch),
        .ex_flag_we (ex_flag_we),
        .ex_flags   (ex_flags),
        .issue_fire (issue_fire),
        .issue_exec (issue_exec),
        .flush      (flush),
        .status_reg (status_reg),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural meaning of each condition code, written from the ISA table.
    function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pending    = 0;
        m_status     = 4'b0000;
        m_flush_left = 0;
    endtask

    // Expected combinational outputs from model state and current inputs.
    task automatic model_eval();
        bit         flags_final;
        bit         must_wait;
        logic [3:0] f;
        f           = m_status;
        flags_final = (m_pending == 0);
`ifdef FLAG_BYPASS_EN
        if (ex_flag_we && m_pending == 1) begin
            f           = ex_flags;
            flags_final = 1'b1;
        end
`endif
        must_wait = (id_cond != 4'hE && !flags_final) ||
                    (id_s && m_pending == MAX_PEND && !ex_flag_we);
        e_ready = (m_flush_left == 0) && !must_wait;
        e_fire  = id_valid && e_ready;
        e_exec  = e_fire && ref_cond(id_cond, f);
    endtask

    // Advance one clock: model consumes the pre-edge inputs.
    task automatic tick();
        int old_p;
        model_eval();
        @(posedge clk);
        old_p = m_pending;
        if (e_exec && id_branch)  m_flush_left = FLUSH_CYCLES;
        else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        if (e_exec && id_s)        m_pending = m_pending + 1;
        if (ex_flag_we && old_p != 0) m_pending = m_pending - 1;
        if (ex_flag_we)            m_status = ex_flags;
        #1;
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_cond    = 4'hE;
        id_s       = 1'b0;
        id_branch  = 1'b0;
        ex_flag_we = 1'b0;
        ex_flags   = 4'h0;
    endtask

    task automatic test_reset();
        // Power-on reset state
        id_valid = 1'b1;
        #3;
        n_tests++; if (status_reg !== 4'b0000) begin n_fail++; $display("FAIL por_status got=%b exp=0000", status_reg); end
        n_tests++; if (pending !== '0) begin n_fail++; $display("FAIL por_pending got=%0d exp=0", pending); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL por_flush got=%b exp=0", flush); end
        n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL por_ready got=%b exp=1", id_ready); end
        id_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Build up non-reset state, then enter FLUSH
        id_valid = 1'b1; id_s = 1'b1; id_cond = 4'hE;
        tick();
        ex_flag_we = 1'b1; ex_flags = 4'b1010;
        tick();
        ex_flag_we = 1'b0; id_s = 1'b0; id_branch = 1'b1;
        tick();
        id_branch = 1'b0;
        @(negedge clk);
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rst_pre_flush got=%b exp=1", flush); end
        n_tests++; if (pending !== PEND_W'(1)) begin n_fail++; $display("FAIL rst_pre_pending got=%0d exp=1", pending); end

        // Asynchronous reset mid-flush: outputs settle without a clock edge
        rst = 1'b1;
        #1;
        n_tests++; if (status_reg !== 4'b0000) begin n_fail++; $display("FAIL rst_status got=%b exp=0000", status_reg); end
        n_tests++; if (pending !== '0) begin n_fail++; $display("FAIL rst_pending got=%0d exp=0", pending); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got=%b exp=0", flush); end
        n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", id_ready); end
        id_valid = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_eq_after_setter();
        idle_inputs();
        id_valid = 1'b1; id_s = 1'b1; id_cond = 4'hE;
        @(negedge clk);
        n_tests++; if (issue_exec !== 1'b1) begin n_fail++; $display("FAIL eq_setter_issue got=%b exp=1", issue_exec); end
        tick();
        id_s = 1'b0; id_cond = 4'h0;
        @(negedge clk);
        n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL eq_stall got=%b exp=0", id_ready); end
        tick();
        // Cycle t: the flag writer retires with Z=1
        ex_flag_we = 1'b1; ex_flags = 4'b0100;
        @(negedge clk);
`ifdef FLAG_BYPASS_EN
        n_tests++; if (issue_exec !== 1'b1) begin n_fail++; $display("FAIL eq_t_exec got=%b exp=1", issue_exec); end
        tick();
        id_valid = 1'b0; ex_flag_we = 1'b0;
`else
        n_tests++; if (issue_exec !== 1'b0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL eq_t_exec got=%b/%b exp=0/0", issue_exec, id_ready); end
        tick();
        ex_flag_we = 1'b0;
        @(negedge clk);
        n_tests++; if (issue_exec !== 1'b1) begin n_fail++; $display("FAIL eq_t1_exec got=%b exp=1", issue_exec); end
        n_tests++; if (status_reg !== 4'b0100 || pending !== '0) begin n_fail++; $display("FAIL eq_t1_state got=%b/%0d exp=0100/0", status_reg, pending); end
        tick();
        id_valid = 1'b0;
`endif
        tick();
    endtask

    task automatic test_cond_sweep();
        logic [3:0] conds_a [6];
        bit         exp_a   [6];
        conds_a = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'hE};
        exp_a   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        ex_flag_we = 1'b1; ex_flags = 4'b1001;
        tick();
        ex_flag_we = 1'b0; id_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_cond = conds_a[i];
            #1;
            n_tests++;
            if (issue_exec !== exp_a[i]) begin
                n_fail++; $display("FAIL sweep_1001 cond=%h got=%b exp=%b", conds_a[i], issue_exec, exp_a[i]);
            end
        end
        id_valid = 1'b0;
        ex_flag_we = 1'b1; ex_flags = 4'b0010;
        tick();
        ex_flag_we = 1'b0; id_valid = 1'b1;
        id_cond = 4'h8; #1;
        n_tests++; if (issue_exec !== 1'b1) begin n_fail++; $display("FAIL sweep_HI got=%b exp=1", issue_exec); end
        id_cond = 4'h9; #1;
        n_tests++; if (issue_exec !== 1'b0 || issue_fire !== 1'b1) begin n_fail++; $display("FAIL sweep_LS got=%b/%b exp=0/1", issue_exec, issue_fire); end
        id_valid = 1'b0;
        tick();
    endtask

    task automatic test_branch();
        idle_inputs();
        id_valid = 1'b1; id_branch = 1'b1; id_cond = 4'hE;
        @(negedge clk);
        n_tests++; if (issue_exec !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL br_issue got=%b/%b exp=1/0", issue_exec, flush); end
        tick();
        id_branch = 1'b0;
        for (int k = 1; k <= FLUSH_CYCLES; k++) begin
            @(negedge clk);
            n_tests++;
            if (flush !== 1'b1 || id_ready !== 1'b0) begin
                n_fail++; $display("FAIL br_flush_%0d got=%b/%b exp flush/ready=1/0", k, flush, id_ready);
            end
            tick();
        end
        @(negedge clk);
        n_tests++; if (flush !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL br_resume got=%b/%b exp=0/1", flush, id_ready); end
        id_valid = 1'b0;
        // Failed branch: NE with Z=1
        ex_flag_we = 1'b1; ex_flags = 4'b0100;
        tick();
        ex_flag_we = 1'b0; id_valid = 1'b1; id_branch = 1'b1; id_cond = 4'h1;
        @(negedge clk);
        n_tests++; if (issue_fire !== 1'b1 || issue_exec !== 1'b0) begin n_fail++; $display("FAIL br_fail_issue got=%b/%b exp=1/0", issue_fire, issue_exec); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_fail_noflush got=%b exp=0", flush); end
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        id_valid = 1'b1; id_s = 1'b1; id_cond = 4'hE;
        repeat (MAX_PEND) tick();
        @(negedge clk);
        n_tests++; if (pending !== PEND_W'(MAX_PEND)) begin n_fail++; $display("FAIL sat_full got=%0d exp=%0d", pending, MAX_PEND); end
        n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall got=%b exp=0", id_ready); end
        tick();
        ex_flag_we = 1'b1; ex_flags = 4'b0011;
        @(negedge clk);
        n_tests++; if (issue_fire !== 1'b1 || issue_exec !== 1'b1) begin n_fail++; $display("FAIL sat_issue got=%b/%b exp=1/1", issue_fire, issue_exec); end
        tick();
        id_valid = 1'b0; ex_flag_we = 1'b0;
        @(negedge clk);
        n_tests++; if (pending !== PEND_W'(MAX_PEND)) begin n_fail++; $display("FAIL sat_after got=%0d exp=%0d", pending, MAX_PEND); end
        tick();
    endtask

    task automatic test_spurious();
        idle_inputs();
        ex_flag_we = 1'b1;
        repeat (MAX_PEND) tick();
        ex_flags = 4'b1111;
        @(negedge clk);
        n_tests++; if (pending !== '0) begin n_fail++; $display("FAIL spur_drained got=%0d exp=0", pending); end
        tick();
        ex_flag_we = 1'b0;
        @(negedge clk);
        n_tests++; if (status_reg !== 4'b1111 || pending !== '0) begin n_fail++; $display("FAIL spur_write got=%b/%0d exp=1111/0", status_reg, pending); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_status;
        int         exp_pend;
        for (int i = 0; i < 1500; i++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_cond    = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            id_s       = ($urandom_range(0, 2) == 0);
            id_branch  = ($urandom_range(0, 7) == 0);
            ex_flag_we = ($urandom_range(0, 2) == 0);
            ex_flags   = 4'($urandom_range(0, 15));
            @(negedge clk);
            model_eval();
            exp_status = m_status;
            exp_pend   = m_pending;
            n_tests++;
            if (id_ready !== e_ready || issue_fire !== e_fire || issue_exec !== e_exec ||
                flush !== (m_flush_left > 0) || status_reg !== exp_status ||
                pending !== PEND_W'(exp_pend)) begin
                n_fail++;
                $display("FAIL rand_%0d got rdy=%b fire=%b exec=%b flush=%b st=%b pend=%0d exp rdy=%b fire=%b exec=%b flush=%b st=%b pend=%0d",
                         i, id_ready, issue_fire, issue_exec, flush, status_reg, pending,
                         e_ready, e_fire, e_exec, (m_flush_left > 0), exp_status, exp_pend);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_eq_after_setter();
        test_cond_sweep();
        test_branch();
        test_saturation();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
